sort_unpacker: RTL and testbench

- Output-side counterpart of the even-odd merge sorting network.
- Accepts one sorted (DATW<<P_LOG)-bit vector per DINEN pulse and buffers it in a wide FIFO, because the network cannot stall.
- Serializes each vector one record per transfer onto a valid/ready stream, and tells the upstream issuer whether it may inject another vector into the network.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_unpack_fifo.sv | 71 +++++++
 rtl/sort_unpacker.sv | 136 +++++++++++++
 tb/tb_sort_unpacker.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the even-odd merge sorter and its output unpacker.
//   sort_net_latency(p_log) : pipeline depth of the sorting network in cycles.
//   REC_KEY_LSB / rec_payload_lsb(keyw) : record field layout. The key sits in
//     the low KEYW bits of each record and the payload sits above it.
package sort_pkg;

    localparam int unsigned REC_KEY_LSB = 0;

    function automatic int unsigned sort_net_latency(input int unsigned p_log);
        return p_log * (p_log + 1) + 1;
    endfunction

    function automatic int unsigned rec_payload_lsb(input int unsigned keyw);
        return REC_KEY_LSB + keyw;
    endfunction

endpackage

// File: rtl/sort_unpack_fifo.sv
// Wide synchronous FIFO that holds whole sorted vectors.
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle. Head data is presented combinationally (first-word fall-through).
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_wdata   write request and data
//   i_pop             remove the head entry (ignored when empty)
//   o_rdata           head entry
//   o_count           number of stored entries (0..2^DEPTH_LOG)
//   o_full, o_empty   derived from o_count
module sort_unpack_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    input  logic [WIDTH-1:0]     i_wdata,
    output logic [WIDTH-1:0]     o_rdata,
    output logic [DEPTH_LOG:0]   o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [DEPTH_LOG-1:0] r_wptr;
    logic [DEPTH_LOG-1:0] r_rptr;
    logic [DEPTH_LOG:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == (DEPTH_LOG+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_pop  = i_pop && !o_empty;
    // When full, the slot being freed by the pop is the one the tail points at.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sort_unpacker.sv
// Output side of the even-odd merge sorter. Buffers each sorted vector in a
// wide FIFO (the network cannot stall), serializes it one record per transfer
// onto a valid/ready stream and grants issue credit to the upstream injector.
// Optional feature macro: SORT_UNPACK_REVERSE_EN emits each vector from the
// highest record index down to record 0.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   ISSUE         upstream injected a vector into the sorter this cycle
//   ALLOW         upstream may inject (registered decode, no path from ISSUE)
//   DIN, DINEN    sorted vector from the sorter and its valid strobe
//   DOT, DOTEN    current record and its valid
//   DOTRDY        downstream accepts DOT
//   DOTLAST       DOT is the final record of its vector
//   OVF           sticky: a vector arrived with no room and was dropped
module sort_unpacker
    import sort_pkg::*;
#(
    parameter int unsigned P_LOG    = 4,
    parameter int unsigned DATW     = 64,
    parameter int unsigned KEYW     = 32,
    parameter int unsigned FIFO_LOG = 3,
    parameter int unsigned NET_LAT  = sort_net_latency(P_LOG)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      ISSUE,
    output logic                      ALLOW,
    input  logic [(DATW<<P_LOG)-1:0]  DIN,
    input  logic                      DINEN,
    output logic [DATW-1:0]           DOT,
    output logic                      DOTEN,
    input  logic                      DOTRDY,
    output logic                      DOTLAST,
    output logic                      OVF
);

    localparam int unsigned VECW  = DATW << P_LOG;
    localparam int unsigned DEPTH = 1 << FIFO_LOG;
    localparam int unsigned CRW   = FIFO_LOG + 2;
    localparam int unsigned SUMW  = FIFO_LOG + 3;
    localparam logic [P_LOG-1:0] IDX_MAX = P_LOG'((1 << P_LOG) - 1);
`ifdef SORT_UNPACK_REVERSE_EN
    localparam logic [P_LOG-1:0] IDX_FIRST = IDX_MAX;
    localparam logic [P_LOG-1:0] IDX_FINAL = '0;
`else
    localparam logic [P_LOG-1:0] IDX_FIRST = '0;
    localparam logic [P_LOG-1:0] IDX_FINAL = IDX_MAX;
`endif

    // Key is passed through untouched, but it must fit inside a record.
    if (rec_payload_lsb(KEYW) > DATW || KEYW == 0) begin : g_bad_keyw
        $error("sort_unpacker: KEYW=%0d does not fit in DATW=%0d", KEYW, DATW);
    end
    if (NET_LAT < sort_net_latency(P_LOG)) begin : g_bad_net_lat
        $error("sort_unpacker: NET_LAT=%0d shorter than the network", NET_LAT);
    end

    logic [P_LOG-1:0]  r_idx;
    logic [P_LOG-1:0]  w_idx_nxt;
    logic [CRW-1:0]    r_inflight;
    logic [CRW-1:0]    w_inflight_nxt;
    logic              r_ovf;
    logic [VECW-1:0]   w_head;
    logic [FIFO_LOG:0] w_used;
    logic              w_full;
    logic              w_empty;
    logic              w_xfer;
    logic              w_pop;
    logic [SUMW-1:0]   w_credit_sum;

    sort_unpack_fifo #(
        .WIDTH     (VECW),
        .DEPTH_LOG (FIFO_LOG)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (DINEN),
        .i_pop   (w_pop),
        .i_wdata (DIN),
        .o_rdata (w_head),
        .o_count (w_used),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign DOTEN   = !w_empty;
    assign DOT     = w_head[r_idx*DATW +: DATW];
    assign DOTLAST = DOTEN && (r_idx == IDX_FINAL);
    assign w_xfer  = DOTEN && DOTRDY;
    assign w_pop   = w_xfer && DOTLAST;
    assign OVF     = r_ovf;

    // Vectors already in the network count against FIFO space.
    assign w_credit_sum = SUMW'(w_used) + SUMW'(r_inflight);
    assign ALLOW        = (w_credit_sum < SUMW'(DEPTH));

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_xfer) begin
            if (DOTLAST) begin
                w_idx_nxt = IDX_FIRST;
            end else begin
`ifdef SORT_UNPACK_REVERSE_EN
                w_idx_nxt = r_idx - 1'b1;
`else
                w_idx_nxt = r_idx + 1'b1;
`endif
            end
        end
    end

    always_comb begin
        w_inflight_nxt = r_inflight;
        unique case ({ISSUE, DINEN})
            2'b10:   w_inflight_nxt = r_inflight + 1'b1;
            2'b01:   w_inflight_nxt = r_inflight - 1'b1;
            default: w_inflight_nxt = r_inflight;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx      <= IDX_FIRST;
            r_inflight <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_inflight <= w_inflight_nxt;
            // Dropped vector: full with no head pop to make room this cycle.
            if (DINEN && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sort_unpacker.sv
module tb_sort_unpacker;

    localparam int unsigned P_LOG    = 2;
    localparam int unsigned DATW     = 8;
    localparam int unsigned KEYW     = 8;
    localparam int unsigned FIFO_LOG = 1;
    localparam int unsigned NET_LAT  = 7;

    localparam logic [31:0] VA = 32'h04030201;
    localparam logic [31:0] VB = 32'h08070605;
    localparam logic [31:0] VC = 32'h0c0b0a09;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ISSUE = 1'b0;
    logic        ALLOW;
    logic [31:0] DIN = '0;
    logic        DINEN = 1'b0;
    logic [7:0]  DOT;
    logic        DOTEN;
    logic        DOTRDY = 1'b0;
    logic        DOTLAST;
    logic        OVF;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sort_unpacker #(
        .P_LOG    (P_LOG),
        .DATW     (DATW),
        .KEYW     (KEYW),
        .FIFO_LOG (FIFO_LOG),
        .NET_LAT  (NET_LAT)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ISSUE   (ISSUE),
        .ALLOW   (ALLOW),
        .DIN     (DIN),
        .DINEN   (DINEN),
        .DOT     (DOT),
        .DOTEN   (DOTEN),
        .DOTRDY  (DOTRDY),
        .DOTLAST (DOTLAST),
        .OVF     (OVF)
    );

    // One row = inputs for a cycle plus the outputs expected before its edge.
    typedef struct {
        string       nm;
        bit          rst;
        bit          iss;
        bit          den;
        logic [31:0] din;
        bit          rdy;
        bit          en;
        logic [31:0] vec;
        int          pos;
        bit          last;
        bit          allow;
        bit          ovf;
    } row_t;

    row_t tbl[$];

    function automatic row_t row(string nm, bit rst, bit iss, bit den, logic [31:0] din,
                                 bit rdy, bit en, logic [31:0] vec, int pos, bit last,
                                 bit allow, bit ovf);
        row_t r;
        r.nm = nm; r.rst = rst; r.iss = iss; r.den = den; r.din = din; r.rdy = rdy;
        r.en = en; r.vec = vec; r.pos = pos; r.last = last; r.allow = allow; r.ovf = ovf;
        return r;
    endfunction

    // Record expected at emission position pos of vector v.
    function automatic logic [7:0] exp_byte(logic [31:0] v, int pos);
`ifdef SORT_UNPACK_REVERSE_EN
        return v[(3-pos)*8 +: 8];
`else
        return v[pos*8 +: 8];
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(string nm, bit en, logic [31:0] vec, int pos, bit last,
                                 bit allow, bit ovf);
        chk({nm, " DOTEN"}, 32'(DOTEN), 32'(en));
        if (en) chk({nm, " DOT"}, 32'(DOT), 32'(exp_byte(vec, pos)));
        chk({nm, " DOTLAST"}, 32'(DOTLAST), 32'(last));
        chk({nm, " ALLOW"}, 32'(ALLOW), 32'(allow));
        chk({nm, " OVF"}, 32'(OVF), 32'(ovf));
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        RST = 1'b1; ISSUE = 1'b0; DINEN = 1'b0; DIN = '0; DOTRDY = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        // Single vector, full-rate drain.
        tbl.push_back(row("single", 1, 1, 1, VA, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row("single", 0, 0, 0, 0, 1, 1, VA, 0, 0, 1, 0));
        tbl.push_back(row("single", 0, 0, 0, 0, 1, 1, VA, 1, 0, 1, 0));
        tbl.push_back(row("single", 0, 0, 0, 0, 1, 1, VA, 2, 0, 1, 0));
        tbl.push_back(row("single", 0, 0, 0, 0, 1, 1, VA, 3, 1, 1, 0));
        tbl.push_back(row("single", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        // Backpressure every other cycle.
        tbl.push_back(row("bp", 1, 1, 1, VA, 0, 0, 0, 0, 0, 1, 0));
        for (int p = 0; p < 4; p++) begin
            tbl.push_back(row("bp", 0, 0, 0, 0, 0, 1, VA, p, p == 3, 1, 0));
            tbl.push_back(row("bp", 0, 0, 0, 0, 1, 1, VA, p, p == 3, 1, 0));
        end
        tbl.push_back(row("bp", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // Credit: two issues close the window until a vector fully drains.
        tbl.push_back(row("credit", 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row("credit", 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row("credit", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row("credit", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(row("credit", 0, 0, 1, VA, 1, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < 4; p++)
            tbl.push_back(row("credit", 0, 0, 0, 0, 1, 1, VA, p, p == 3, 0, 0));
        tbl.push_back(row("credit", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        // Overflow: third vector into a stalled, full FIFO is dropped.
        tbl.push_back(row("ovf", 1, 1, 1, VA, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row("ovf", 0, 1, 1, VB, 0, 1, VA, 0, 0, 1, 0));
        tbl.push_back(row("ovf", 0, 1, 1, VC, 0, 1, VA, 0, 0, 0, 0));
        tbl.push_back(row("ovf", 0, 0, 0, 0, 0, 1, VA, 0, 0, 0, 1));
        for (int p = 0; p < 4; p++)
            tbl.push_back(row("ovf", 0, 0, 0, 0, 1, 1, VA, p, p == 3, 0, 1));
        for (int p = 0; p < 4; p++)
            tbl.push_back(row("ovf", 0, 0, 0, 0, 1, 1, VB, p, p == 3, 1, 1));
        tbl.push_back(row("ovf", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        // Full FIFO, new vector lands on the DOTLAST pop.
        tbl.push_back(row("fullpop", 1, 1, 1, VA, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(row("fullpop", 0, 1, 1, VB, 0, 1, VA, 0, 0, 1, 0));
        tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 1, VA, 0, 0, 0, 0));
        tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 1, VA, 1, 0, 0, 0));
        tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 1, VA, 2, 0, 0, 0));
        tbl.push_back(row("fullpop", 0, 1, 1, VC, 1, 1, VA, 3, 1, 0, 0));
        for (int p = 0; p < 4; p++)
            tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 1, VB, p, p == 3, 0, 0));
        for (int p = 0; p < 4; p++)
            tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 1, VC, p, p == 3, 1, 0));
        tbl.push_back(row("fullpop", 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));

        // Reset state while RST is held from time zero.
        #1;
        check_outputs("por", 0, 0, 0, 0, 1, 0);

        foreach (tbl[i]) begin
            if (tbl[i].rst) reset_pulse();
            @(negedge CLK);
            ISSUE = tbl[i].iss; DINEN = tbl[i].den; DIN = tbl[i].din; DOTRDY = tbl[i].rdy;
            #1;
            check_outputs($sformatf("%s[%0d]", tbl[i].nm, i), tbl[i].en, tbl[i].vec,
                          tbl[i].pos, tbl[i].last, tbl[i].allow, tbl[i].ovf);
        end

        // Asynchronous reset in the middle of a vector with credit outstanding.
        reset_pulse();
        @(negedge CLK);
        ISSUE = 1'b1; DINEN = 1'b1; DIN = VA; DOTRDY = 1'b0;
        #1 check_outputs("rstmid a", 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        ISSUE = 1'b1; DINEN = 1'b0; DIN = '0;
        #1 check_outputs("rstmid b", 1, VA, 0, 0, 1, 0);
        @(negedge CLK);
        ISSUE = 1'b0; DOTRDY = 1'b1;
        #1 check_outputs("rstmid c", 1, VA, 0, 0, 0, 0);
        @(negedge CLK);
        DOTRDY = 1'b0;
        #1 check_outputs("rstmid d", 1, VA, 1, 0, 0, 0);
        RST = 1'b1;
        #1 check_outputs("rstmid async", 0, 0, 0, 0, 1, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        #1 check_outputs("rstmid after", 0, 0, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
